ckce_gen: RTL and testbench

CKCE_GEN -- requirements
Module: ckce_gen

---
 rtl/ckce_pkg.sv | 21 ++
 rtl/glitch_filter.sv | 27 ++
 rtl/ckce_gen.sv | 78 +++++++
 tb/tb_ckce_gen.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ckce_pkg.sv
// ckce_pkg: shared parameter defaults, legal ranges and edge type for the clock-enable generator
package ckce_pkg;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int FILT_LEN_DEF    = 2;
  localparam int FILT_LEN_MIN    = 1;
  localparam int FILT_LEN_MAX    = 15;
  localparam int TIMEOUT_DEF     = 1023;
  localparam int TIMEOUT_MIN     = 1;
  localparam int TIMEOUT_MAX     = 65535;
  localparam int PERIOD_W_DEF    = 16;
  typedef enum logic [1:0] {
    EDGE_NONE,
    EDGE_RISE,
    EDGE_FALL
  } edge_e;
  function automatic bit in_range(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction
endpackage

// File: rtl/glitch_filter.sv
// glitch_filter: accepts a new level only after it has differed from q on FILT_LEN consecutive edges
module glitch_filter
  import ckce_pkg::*;
#(
  parameter int FILT_LEN = FILT_LEN_DEF
) (
  input  logic sysclk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [3:0] cnt;
  // run counter restarts whenever d agrees with q, so only an unbroken run is accepted
  always_ff @(posedge sysclk) begin
    if (reset) begin
      q   <= 1'b0;
      cnt <= '0;
    end else if (d == q) begin
      cnt <= '0;
    end else if (cnt == 4'(FILT_LEN - 1)) begin
      q   <= d;
      cnt <= '0;
    end else begin
      cnt <= cnt + 4'd1;
    end
  end
endmodule

// File: rtl/ckce_gen.sv
// ckce_gen: turns a raw asynchronous board clock into filtered edge enables, period and loss status
module ckce_gen
  import ckce_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_LEN    = FILT_LEN_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF,
  parameter int PERIOD_W    = PERIOD_W_DEF
) (
  input  logic                sysclk,
  input  logic                reset,
  input  logic                clk_in,
  output logic                ck_lvl,
  output logic                ck_ce_rise,
  output logic                ck_ce_fall,
  output logic [PERIOD_W-1:0] period,
  output logic                period_vld,
  output logic                clk_lost
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [PERIOD_W-1:0] PMAX = {PERIOD_W{1'b1}};
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  if (!in_range(SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX) ||
      !in_range(FILT_LEN, FILT_LEN_MIN, FILT_LEN_MAX) ||
      !in_range(TIMEOUT, TIMEOUT_MIN, TIMEOUT_MAX)) begin : g_bad_param
    $error("ckce_gen: parameter out of legal range");
  end
  logic [SYNC_STAGES-1:0] sync;
  logic                   lvl_d;
  logic                   seen_rise;
  logic [PERIOD_W-1:0]    pcnt;
  logic [PERIOD_W-1:0]    pcnt_inc;
  logic [TW-1:0]          tcnt;
  edge_e                  edge_kind;
  logic                   rise_n;
  logic                   fall_n;
  // plain flop chain: clk_in is metastability-hardened before anything else sees it
  always_ff @(posedge sysclk) begin
    sync <= reset ? '0 : {sync[SYNC_STAGES-2:0], clk_in};
  end
  glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt (
    .sysclk(sysclk),
    .reset (reset),
    .d     (sync[SYNC_STAGES-1]),
    .q     (ck_lvl)
  );
  // edge classification of the filtered level and saturating period increment
  always_comb begin
    edge_kind = (ck_lvl && !lvl_d) ? EDGE_RISE : (!ck_lvl && lvl_d) ? EDGE_FALL : EDGE_NONE;
    rise_n    = edge_kind == EDGE_RISE;
    fall_n    = edge_kind == EDGE_FALL;
    pcnt_inc  = (pcnt == PMAX) ? PMAX : pcnt + PERIOD_W'(1);
  end
  // registered enables; period restarts after each rise, loss timer clears with each enable
  always_ff @(posedge sysclk) begin
    if (reset) begin
      lvl_d      <= 1'b0;
      ck_ce_rise <= 1'b0;
      ck_ce_fall <= 1'b0;
      pcnt       <= '0;
      period     <= '0;
      period_vld <= 1'b0;
      seen_rise  <= 1'b0;
      tcnt       <= '0;
      clk_lost   <= 1'b0;
    end else begin
      lvl_d      <= ck_lvl;
      ck_ce_rise <= rise_n;
      ck_ce_fall <= fall_n;
      pcnt       <= ck_ce_rise ? PERIOD_W'(1) : pcnt_inc;
      period     <= rise_n ? pcnt_inc : period;
      period_vld <= rise_n && seen_rise;
      seen_rise  <= seen_rise || rise_n;
      tcnt       <= (rise_n || fall_n) ? '0 : (tcnt == TMAX) ? tcnt : tcnt + TW'(1);
      clk_lost   <= tcnt == TMAX;
    end
  end
endmodule

// File: tb/tb_ckce_gen.sv
// tb_ckce_gen: scoreboard bench for ckce_gen with directed clk_in vectors and a random jitter phase
module tb_ckce_gen;
  logic        sysclk = 1'b0;
  logic        reset  = 1'b1;
  logic        clk_in = 1'b0;
  logic        ck_lvl, ck_ce_rise, ck_ce_fall, period_vld, clk_lost;
  logic [15:0] period;
  logic        ck_lvl4, ck_ce_rise4, ck_ce_fall4, period_vld4, clk_lost4;
  logic [3:0]  period4;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  typedef struct {
    int at;
    bit rise;
    bit vld;
    int per;
  } ev_t;
  ev_t sb[$];
  bit  have_prev = 0;
  int  prev_rise = 0;
  int  last_pulse = 0;
  bit  free_run = 0;
  bit  last_rise = 0;

  ckce_gen dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .clk_in    (clk_in),
    .ck_lvl    (ck_lvl),
    .ck_ce_rise(ck_ce_rise),
    .ck_ce_fall(ck_ce_fall),
    .period    (period),
    .period_vld(period_vld),
    .clk_lost  (clk_lost)
  );

  ckce_gen #(.PERIOD_W(4)) dut4 (
    .sysclk    (sysclk),
    .reset     (reset),
    .clk_in    (clk_in),
    .ck_lvl    (ck_lvl4),
    .ck_ce_rise(ck_ce_rise4),
    .ck_ce_fall(ck_ce_fall4),
    .period    (period4),
    .period_vld(period_vld4),
    .clk_lost  (clk_lost4)
  );

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic push(input bit v, input int at);
    ev_t e;
    e.at   = at;
    e.rise = v;
    e.vld  = v && have_prev;
    e.per  = at - prev_rise;
    if (v) begin
      prev_rise = at;
      have_prev = 1;
    end
    last_pulse = at;
    sb.push_back(e);
  endtask

  task automatic edge_in(input bit v, input int hold);
    clk_in = v;
    push(v, cyc + 5);
    repeat (hold) tick();
  endtask

  task automatic glitch(input int w, input bit expect_pulse);
    int c;
    c = cyc;
    clk_in = 1'b1;
    if (expect_pulse) push(1'b1, c + 5);
    repeat (w) tick();
    clk_in = 1'b0;
    if (expect_pulse) push(1'b0, c + w + 5);
    repeat (20) tick();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_lvl"}, ck_lvl, 0);
    chk({tag, "_rise"}, ck_ce_rise, 0);
    chk({tag, "_fall"}, ck_ce_fall, 0);
    chk({tag, "_vld"}, period_vld, 0);
    chk({tag, "_lost"}, clk_lost, 0);
    chk({tag, "_period"}, period, 0);
  endtask

  // monitor: every enable pulse is checked for exclusivity, alternation and against the scoreboard
  always @(negedge sysclk) begin
    if (reset) begin
      last_rise = 0;
    end else if (ck_ce_rise || ck_ce_fall) begin
      chk("excl", ck_ce_rise && ck_ce_fall, 0);
      chk("alternate", ck_ce_rise, !last_rise);
      chk("dut4_rise", ck_ce_rise4, ck_ce_rise);
      last_rise = ck_ce_rise;
      if (!free_run) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_pulse @cyc %0d: got rise=%0d fall=%0d expected none", cyc, ck_ce_rise, ck_ce_fall);
        end else begin
          ev_t e;
          e = sb.pop_front();
          chk("pulse_cycle", cyc, e.at);
          chk("pulse_kind", ck_ce_rise, e.rise);
          if (e.rise) begin
            chk("period_vld", period_vld, e.vld);
            chk("period_vld4", period_vld4, e.vld);
            if (e.vld) begin
              chk("period", period, e.per);
              chk("period4", period4, (e.per > 15) ? 15 : e.per);
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    repeat (3) tick();
    chk_reset_outs("rst");
    reset = 1'b0;
    repeat (10) tick();
    for (int i = 0; i < 5; i++) begin
      edge_in(1'b1, 20);
      edge_in(1'b0, 20);
    end
    for (int i = 0; i < 3; i++) begin
      edge_in(1'b1, 15);
      edge_in(1'b0, 15);
    end
    for (int i = 0; i < 3; i++) begin
      edge_in(1'b1, 5);
      edge_in(1'b0, 5);
    end
    repeat (20) tick();
    glitch(1, 1'b0);
    glitch(3, 1'b1);
    while (cyc < last_pulse + 1023) tick();
    chk("lost_before", clk_lost, 0);
    tick();
    chk("lost_rise", clk_lost, 1);
    while (cyc < last_pulse + 1100) tick();
    chk("lost_held", clk_lost, 1);
    c = cyc;
    edge_in(1'b1, 5);
    chk("lost_at_pulse", clk_lost, 1);
    tick();
    chk("lost_clear", clk_lost, 0);
    repeat (14) tick();
    edge_in(1'b0, 20);
    c = cyc;
    clk_in = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
    have_prev = 0;
    repeat (3) begin
      tick();
      chk("rst_mid_rise", ck_ce_rise, 0);
      chk("rst_mid_lvl", ck_lvl, 0);
    end
    reset = 1'b0;
    push(1'b1, c + 10);
    repeat (20) tick();
    edge_in(1'b0, 20);
    edge_in(1'b1, 20);
    edge_in(1'b0, 20);
    chk("sb_drained", sb.size(), 0);
    free_run = 1;
    for (int i = 0; i < 2000; i++) begin
      clk_in = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 8)) tick();
    end
    clk_in = 1'b0;
    repeat (30) tick();
    chk("final_lvl", ck_lvl, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
